// File: rtl/led_scanner_if.sv
// led_scanner_if: control/status bundle between an LED scanner and whatever
// drives it (board logic or a testbench).
//   en         - prescaler count enable (master -> scanner)
//   mode       - 00 bounce, 01 rotate-left, 10 rotate-right, 11 freeze
//   div        - step period minus one, in enabled clocks
//   dwell      - extra step periods spent at each bounce edge
//   led        - registered LED pattern (scanner -> master)
//   dir        - registered direction, 1 = toward MSB
//   edge_pulse - one-cycle pulse after each bounce reversal
interface led_scanner_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) ();
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [3:0]       dwell;
  logic [WIDTH-1:0] led;
  logic             dir;
  logic             edge_pulse;

  modport master (
    output en, mode, div, dwell,
    input  led, dir, edge_pulse
  );

  modport slave (
    input  en, mode, div, dwell,
    output led, dir, edge_pulse
  );
endinterface

// File: rtl/led_scanner.sv
// led_scanner: moves a lit bar of BAR adjacent LEDs across a WIDTH-bit LED
// bank in bounce, rotate-left, rotate-right or freeze mode. A programmable
// prescaler sets the step rate; bounce mode can dwell at each edge.
// Ports:
//   clk   - single clock, all state changes on its rising edge
//   rst_n - synchronous active-low reset
//   bus   - led_scanner_if.slave: en/mode/div/dwell in, led/dir/edge_pulse out
module led_scanner #(
  parameter int WIDTH = 8,
  parameter int BAR   = 1,
  parameter int DIV_W = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  led_scanner_if.slave  bus
);

  localparam int POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [POS_W-1:0] POS_ZERO = POS_W'(0);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(WIDTH - BAR);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROT_L  = 2'b01;
  localparam logic [1:0] MODE_ROT_R  = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  // Bit i lit iff (i - p) mod WIDTH < BAR; wraps across MSB/LSB.
  function automatic logic [WIDTH-1:0] bar_mask(input logic [POS_W-1:0] p);
    logic [WIDTH-1:0] m;
    int               d;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= int'(p)) begin
        d = i - int'(p);
      end else begin
        d = i + WIDTH - int'(p);
      end
      m[i] = (d < BAR);
    end
    return m;
  endfunction

  // Modular +1/-1 so non-power-of-two widths wrap correctly.
  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return (p == POS_LAST) ? POS_ZERO : p + POS_ONE;
  endfunction

  function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
    return (p == POS_ZERO) ? POS_LAST : p - POS_ONE;
  endfunction

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [3:0]       dwell_cnt_q, dwell_cnt_d;
  logic             edge_q, edge_d;
  logic [WIDTH-1:0] led_q;
  logic             tick_s;

  // Prescaler and next-state position/direction/dwell logic.
  always_comb begin
    // >= rather than == so lowering div below cnt ticks immediately
    tick_s      = bus.en && (cnt_q >= bus.div);
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    dwell_cnt_d = dwell_cnt_q;
    edge_d      = 1'b0;

    if (tick_s) begin
      cnt_d = '0;
    end else if (bus.en) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    if (tick_s) begin
      case (bus.mode)
        MODE_FREEZE: begin
          dwell_cnt_d = 4'd0;
        end
        MODE_ROT_L: begin
          dir_d       = 1'b1;
          pos_d       = pos_inc(pos_q);
          dwell_cnt_d = 4'd0;
        end
        MODE_ROT_R: begin
          dir_d       = 1'b0;
          pos_d       = pos_dec(pos_q);
          dwell_cnt_d = 4'd0;
        end
        MODE_BOUNCE: begin
          if (pos_q > POS_MAX) begin
            // Bar was left wrapped by a rotate: snap to the top edge quietly.
            pos_d       = POS_MAX;
            dir_d       = 1'b0;
            dwell_cnt_d = 4'd0;
          end else if (dwell_cnt_q != 4'd0) begin
            dwell_cnt_d = dwell_cnt_q - 4'd1;
          end else if (dir_q && (pos_q == POS_MAX)) begin
            dir_d  = 1'b0;
            edge_d = 1'b1;
            if (bus.dwell == 4'd0) begin
              pos_d = pos_q - POS_ONE;
            end else begin
              // This tick already counts as one of the dwell periods.
              dwell_cnt_d = bus.dwell - 4'd1;
            end
          end else if (!dir_q && (pos_q == POS_ZERO)) begin
            dir_d  = 1'b1;
            edge_d = 1'b1;
            if (bus.dwell == 4'd0) begin
              pos_d = pos_q + POS_ONE;
            end else begin
              dwell_cnt_d = bus.dwell - 4'd1;
            end
          end else if (dir_q) begin
            pos_d = pos_q + POS_ONE;
          end else begin
            pos_d = pos_q - POS_ONE;
          end
        end
        default: begin
          dwell_cnt_d = 4'd0;
        end
      endcase
    end else begin
      edge_d = 1'b0;
    end
  end

  // State and output registers; led is built from next-state pos so it
  // always matches the current pos with no extra latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pos_q       <= POS_ZERO;
      dir_q       <= 1'b1;
      dwell_cnt_q <= 4'd0;
      edge_q      <= 1'b0;
      led_q       <= bar_mask(POS_ZERO);
    end else begin
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      dwell_cnt_q <= dwell_cnt_d;
      edge_q      <= edge_d;
      led_q       <= bar_mask(pos_d);
    end
  end

  assign bus.led        = led_q;
  assign bus.dir        = dir_q;
  assign bus.edge_pulse = edge_q;

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed, table-driven bench for led_scanner. Instance A
// uses BAR=1, instance B uses BAR=3, both WIDTH=8. A vector table covers
// legacy bounce, wide-bar bounce, rotate and rotate-to-bounce recovery;
// hand-written sequences cover prescaler, enable hold, div change, dwell,
// freeze and reset during dwell.
module tb_led_scanner;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  led_scanner_if #(.WIDTH(8), .DIV_W(24)) ifa ();
  led_scanner_if #(.WIDTH(8), .DIV_W(24)) ifb ();

  led_scanner #(.WIDTH(8), .BAR(1), .DIV_W(24)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  led_scanner #(.WIDTH(8), .BAR(3), .DIV_W(24)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ma;
    logic [1:0] mb;
    logic [7:0] a_led;
    logic       a_dir;
    logic       a_pls;
    logic [7:0] b_led;
    logic       b_dir;
    logic       b_pls;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] ma, input logic [1:0] mb,
                     input logic [7:0] al, input logic ad, input logic ap,
                     input logic [7:0] bl, input logic bd, input logic bp);
    vec_t v;
    v.ma = ma; v.mb = mb;
    v.a_led = al; v.a_dir = ad; v.a_pls = ap;
    v.b_led = bl; v.b_dir = bd; v.b_pls = bp;
    vecs.push_back(v);
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b", name, got, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [7:0] l, input logic d, input logic p);
    chk8({name, " a_led"}, ifa.led, l);
    chk1({name, " a_dir"}, ifa.dir, d);
    chk1({name, " a_pulse"}, ifa.edge_pulse, p);
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Edges 1..16: both bounce from reset. Edges 17..28: A frozen,
    // B rotates left, right, left again, then returns to bounce.
    add(2'd0, 2'd0, 8'h02, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h04, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h08, 1'b1, 1'b0, 8'h38, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h10, 1'b1, 1'b0, 8'h70, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h20, 1'b1, 1'b0, 8'hE0, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h40, 1'b1, 1'b0, 8'h70, 1'b0, 1'b1);
    add(2'd0, 2'd0, 8'h80, 1'b1, 1'b0, 8'h38, 1'b0, 1'b0);
    add(2'd0, 2'd0, 8'h40, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0);
    add(2'd0, 2'd0, 8'h20, 1'b0, 1'b0, 8'h0E, 1'b0, 1'b0);
    add(2'd0, 2'd0, 8'h10, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
    add(2'd0, 2'd0, 8'h08, 1'b0, 1'b0, 8'h0E, 1'b1, 1'b1);
    add(2'd0, 2'd0, 8'h04, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h02, 1'b0, 1'b0, 8'h38, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h01, 1'b0, 1'b0, 8'h70, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h02, 1'b1, 1'b1, 8'hE0, 1'b1, 1'b0);
    add(2'd0, 2'd0, 8'h04, 1'b1, 1'b0, 8'h70, 1'b0, 1'b1);
    add(2'd3, 2'd1, 8'h04, 1'b1, 1'b0, 8'hE0, 1'b1, 1'b0);
    add(2'd3, 2'd1, 8'h04, 1'b1, 1'b0, 8'hC1, 1'b1, 1'b0);
    add(2'd3, 2'd1, 8'h04, 1'b1, 1'b0, 8'h83, 1'b1, 1'b0);
    add(2'd3, 2'd1, 8'h04, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0);
    add(2'd3, 2'd1, 8'h04, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b0);
    add(2'd3, 2'd2, 8'h04, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0);
    add(2'd3, 2'd2, 8'h04, 1'b1, 1'b0, 8'h83, 1'b0, 1'b0);
    add(2'd3, 2'd2, 8'h04, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    add(2'd3, 2'd2, 8'h04, 1'b1, 1'b0, 8'hE0, 1'b0, 1'b0);
    add(2'd3, 2'd1, 8'h04, 1'b1, 1'b0, 8'hC1, 1'b1, 1'b0);
    add(2'd3, 2'd0, 8'h04, 1'b1, 1'b0, 8'hE0, 1'b0, 1'b0);
    add(2'd3, 2'd0, 8'h04, 1'b1, 1'b0, 8'h70, 1'b0, 1'b0);

    // Reset held for two clocks with legacy settings applied.
    rst_n = 1'b0;
    ifa.en = 1'b1; ifa.mode = 2'd0; ifa.div = 24'd0; ifa.dwell = 4'd0;
    ifb.en = 1'b1; ifb.mode = 2'd0; ifb.div = 24'd0; ifb.dwell = 4'd0;
    step();
    step();
    chk_a("reset", 8'h01, 1'b1, 1'b0);
    chk8("reset b_led", ifb.led, 8'h07);
    chk1("reset b_dir", ifb.dir, 1'b1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      ifa.mode = vecs[i].ma;
      ifb.mode = vecs[i].mb;
      step();
      chk_a($sformatf("row%0d", i), vecs[i].a_led, vecs[i].a_dir, vecs[i].a_pls);
      chk8($sformatf("row%0d b_led", i), ifb.led, vecs[i].b_led);
      chk1($sformatf("row%0d b_dir", i), ifb.dir, vecs[i].b_dir);
      chk1($sformatf("row%0d b_pulse", i), ifb.edge_pulse, vecs[i].b_pls);
    end

    // Prescaler: div=3 steps every 4 clocks, first on the 4th edge.
    rst_n = 1'b0; ifa.mode = 2'd0; ifa.div = 24'd3; ifb.mode = 2'd3;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk8($sformatf("div3 wait%0d", k), ifa.led, 8'h01);
    end
    step();
    chk8("div3 step1", ifa.led, 8'h02);
    for (int k = 0; k < 3; k++) begin
      step();
      chk8($sformatf("div3 hold%0d", k), ifa.led, 8'h02);
    end
    step();
    chk8("div3 step2", ifa.led, 8'h04);
    step();
    step();
    // cnt is now 2; disable for 10 cycles and nothing may move.
    ifa.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk8($sformatf("en_low%0d", k), ifa.led, 8'h04);
    end
    ifa.en = 1'b1;
    step();
    chk8("en_resume cnt3", ifa.led, 8'h04);
    step();
    chk8("en_resume step", ifa.led, 8'h08);
    // Count up to 5 under div=9, then lower div to 2: tick on next edge.
    ifa.div = 24'd9;
    for (int k = 0; k < 5; k++) begin
      step();
      chk8($sformatf("div9 count%0d", k), ifa.led, 8'h08);
    end
    ifa.div = 24'd2;
    step();
    chk8("div_lowered tick", ifa.led, 8'h10);

    // Dwell=2 in bounce at one step per clock.
    rst_n = 1'b0; ifa.div = 24'd0; ifa.dwell = 4'd2;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk8("dwell pre", ifa.led, 8'h40);
    step(); chk_a("dwell top1", 8'h80, 1'b1, 1'b0);
    step(); chk_a("dwell top2", 8'h80, 1'b0, 1'b1);
    step(); chk_a("dwell top3", 8'h80, 1'b0, 1'b0);
    step(); chk_a("dwell leave top", 8'h40, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk8("dwell mid", ifa.led, 8'h02);
    step(); chk_a("dwell bot1", 8'h01, 1'b0, 1'b0);
    step(); chk_a("dwell bot2", 8'h01, 1'b1, 1'b1);
    step(); chk_a("dwell bot3", 8'h01, 1'b1, 1'b0);
    step(); chk_a("dwell leave bot", 8'h02, 1'b1, 1'b0);

    // Freeze for 20 clocks.
    ifa.mode = 2'd3;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_a($sformatf("freeze%0d", k), 8'h02, 1'b1, 1'b0);
    end

    // Reset during an active dwell at the top edge.
    ifa.mode = 2'd0;
    for (int k = 0; k < 6; k++) step();
    chk8("pre_dwell top", ifa.led, 8'h80);
    step();
    chk_a("dwell active", 8'h80, 1'b0, 1'b1);
    rst_n = 1'b0;
    step();
    chk_a("reset mid dwell", 8'h01, 1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    chk_a("post reset step", 8'h02, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
# led_scanner

Parametrised LED scanner that moves a lit bar of `BAR` adjacent LEDs across a `WIDTH`-bit LED bank. It supports four modes: bounce, rotate-left, rotate-right and freeze. Step rate comes from an internal programmable prescaler, and bounce mode has a programmable dwell at each edge. It sits between the board clock and the LED pins and replaces the fixed 8-bit, one-step-per-clock side-to-side driver.

## Interface
- `WIDTH`, default 8: number of LEDs; must be ≥ 2.
- `BAR`, default 1: number of adjacent lit LEDs; 1 ≤ `BAR` < `WIDTH`.
- `DIV_W`, default 24: prescaler width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `en` input 1: prescaler count enable. When low, the prescaler and all state hold.
- `mode` input 2: 00 bounce, 01 rotate-left (toward MSB), 10 rotate-right (toward LSB), 11 freeze.
- `div` input `DIV_W`: step period is `div`+1 enabled clocks.
- `dwell` input 4: extra step periods spent at each bounce edge.
- `led` output `WIDTH`: registered LED pattern.
- `dir` output 1: registered direction; 1 = toward MSB, 0 = toward LSB.
- `edge_pulse` output 1: registered, one-cycle pulse on each bounce reversal.

## Operation
- **State:**
  - `cnt` (`DIV_W` bits)
  - `pos` (clog2(`WIDTH`) bits): index of the bar's LSB
  - `dir`
  - `dwell_cnt` (4 bits)
- **Reset** (`rst_n`=0 at a clock edge):
  - `cnt`=0, `pos`=0, `dir`=1, `dwell_cnt`=0
  - `edge_pulse`=0, `led`=BAR ones at bit 0 (e.g. 8'h01 for `BAR`=1)
  - Reset overrides all other inputs.
- **Prescaler:**
  - tick = `en` & (`cnt` ≥ `div`).
  - On tick, `cnt`←0. Otherwise, if `en`=1, `cnt`←`cnt`+1.
  - The ≥ compare means lowering `div` below the current `cnt` gives a tick on the next enabled edge.
- **Per tick, by mode:**
  - **Freeze:** `pos` and `dir` hold; `dwell_cnt`←0.
  - **Rotate-left:** `dir`←1; `pos`←(`pos`+1) mod `WIDTH`; `dwell_cnt`←0.
  - **Rotate-right:** `dir`←0; `pos`←(`pos`−1) mod `WIDTH`; `dwell_cnt`←0.
  - **Bounce, out-of-range** (`pos` > `WIDTH`−`BAR`, only possible after a rotate): `pos`←`WIDTH`−`BAR`, `dir`←0, `dwell_cnt`←0, no `edge_pulse`.
  - **Bounce, dwell active** (`dwell_cnt` > 0): `dwell_cnt`←`dwell_cnt`−1; `pos` holds.
  - **Bounce, left edge** (`dir`=1 and `pos`=`WIDTH`−`BAR`): `dir`←0; `edge_pulse`←1.
    - If `dwell`=0, `pos`←`pos`−1 on the same tick.
    - Otherwise `dwell_cnt`←`dwell`−1 and `pos` holds.
  - **Bounce, right edge** (`dir`=0 and `pos`=0): mirror of the left edge. `dir`←1, `pos`+1 when `dwell`=0.
  - **Bounce, otherwise:** `pos` steps one position in `dir`.
  - The net effect is that an edge position stays displayed for `dwell`+1 step periods.
- **LED mapping:** `led` bit i = 1 iff (i − `pos`) mod `WIDTH` < `BAR`.
  - In bounce mode, with `pos` in range, this gives a non-wrapping bar.
  - In rotate modes the bar wraps across MSB/LSB.
- **Outputs:**
  - `led` is registered from next-state `pos`, so it always equals the mapping of current `pos`.
  - `edge_pulse` is 0 on every cycle except the one following a reversal tick.
- **Mode changes:** `mode`, `dwell` and `div` are sampled every cycle. Only ticks act on `mode` and `dwell`.

## Timing
- Step latency: `led`, `dir` and `edge_pulse` update on the same rising edge where tick is true. There are no extra pipeline stages.
- With `div`=D and `en` held high, consecutive steps are D+1 cycles apart. The first step after reset release occurs on the (D+1)th edge.
- `div`=0 gives one step per clock, which is the legacy behaviour.
- `en` low freezes `cnt` exactly. Counting resumes from the held value.
- Bounce cycle length with `dwell`=0 is 2·(`WIDTH`−`BAR`) steps. Each `dwell`=N adds 2·N steps per cycle.
- Reset mid-dwell or mid-count discards all state. The first post-reset step follows the same (D+1)-edge rule.

## Test plan
1. **Reset and legacy bounce.** `WIDTH`=8, `BAR`=1. Hold `rst_n`=0 for 2 clocks, then release with en=1, div=0, mode=00, dwell=0.
   - During reset: `led`=01, `dir`=1.
   - After release, `led` per clock: 02, 04 … 80, 40 … 01, 02.
   - `edge_pulse` is high exactly on the cycles showing 40 and 02. The period is 14 clocks.
2. **Prescaler.** div=3 gives a step every 4 clocks.
   - Drop en for 10 cycles mid-count: `led` and phase are unchanged; the next step comes after the remaining count.
   - Change div from 9 to 2 while `cnt`=5: a tick occurs on the next edge.
3. **Dwell.** div=0, dwell=2, bounce.
   - 80 is displayed for 3 clocks, then 40.
   - `edge_pulse` fires once, on the cycle right after the first 80 tick. The same holds at 01.
4. **Wide bar and rotate.** `BAR`=3.
   - Bounce: 07, 0E … E0, 70.
   - mode=01 from E0: C1, 83, 07, 0E.
   - mode=10 from 07: 83, C1, E0.
5. **Rotate-to-bounce recovery.** `BAR`=3, rotate-left to `led`=C1 (pos 6), then switch to mode=00.
   - Next tick: `led`=E0, `dir`=0, `edge_pulse`=0.
   - Following tick: 70.
6. **Freeze and reset mid-operation.**
   - mode=11 for 20 clocks: `led` and `dir` are constant and `edge_pulse`=0.
   - Assert `rst_n`=0 for 1 clock during an active dwell: the outputs return to their reset values on that edge.
